// File: rtl/vend_pkg.sv
// Shared types and constants for the vending-machine sequencer.
// Holds the FSM state encoding, coin values and the default vend price.
package vend_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCollect,
    StVend,
    StChange,
    StRefund
  } state_e;

  localparam int unsigned CoinC5Value  = 5;
  localparam int unsigned CoinC10Value = 10;
  localparam int unsigned CoinC25Value = 25;
  localparam int unsigned DefaultPrice = 25;
  localparam int unsigned NickelValue  = 5;

  // Value of a one-hot coin pulse; multi-hot is screened out by the caller.
  function automatic int unsigned coin_value(input logic c5, input logic c10, input logic c25);
    if (c25) begin
      return CoinC25Value;
    end else if (c10) begin
      return CoinC10Value;
    end else if (c5) begin
      return CoinC5Value;
    end
    return 0;
  endfunction

endpackage

// File: rtl/inactivity_timer.sv
// Down-counter that pulses tc_o on the enabled cycle where it expires.
// clr_i reloads the full count and takes priority over counting.
module inactivity_timer #(
  parameter int unsigned Count = 1000
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned CntW = $clog2(Count + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tc_o  = 1'b0;
    if (clr_i) begin
      cnt_d = CntW'(Count);
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CntW'(1);
      tc_o  = (cnt_q == CntW'(1));
    end
  end

  // Once expired the counter parks at zero so tc_o cannot repeat until reloaded.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vend_sequencer.sv
// Vending sequencer: collects coins into credit, runs the vend handshake,
// then pays change or refunds as hopper-paced nickel pulses.
module vend_sequencer
  import vend_pkg::*;
#(
  parameter int unsigned Bits    = 6,
  parameter int unsigned Price   = DefaultPrice,
  parameter int unsigned Timeout = 1000
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            c5_i,
  input  logic            c10_i,
  input  logic            c25_i,
  input  logic            cancel_i,
  input  logic            vend_ack_i,
  input  logic            hopper_ready_i,
  output logic [Bits-1:0] credit_o,
  output logic            coin_accept_o,
  output logic            coin_reject_o,
  output logic            vend_req_o,
  output logic            nickel_out_o,
  output logic            busy_o
);

  localparam logic [Bits-1:0] PriceW  = Bits'(Price);
  localparam logic [Bits-1:0] NickelW = Bits'(NickelValue);

  state_e          state_q, state_d;
  logic [Bits-1:0] credit_q, credit_d;
  logic            accept_q, reject_q, reject_d, vend_req_q, nickel_q, nickel_d, busy_q;

  logic            coin_any, coin_multi, coin_fits;
  logic [Bits:0]   coin_sum;
  logic            tmr_clr, tmr_en, tmr_tc;

  assign coin_any   = c5_i | c10_i | c25_i;
  assign coin_multi = (c5_i & c10_i) | (c5_i & c25_i) | (c10_i & c25_i);
  // One extra bit catches a coin that would overflow the credit register.
  assign coin_sum   = {1'b0, credit_q} + (Bits + 1)'(coin_value(c5_i, c10_i, c25_i));
  assign coin_fits  = ~coin_sum[Bits];
  assign tmr_en     = (state_q == StCollect);

  inactivity_timer #(
    .Count (Timeout)
  ) u_inactivity_timer (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clr_i   (tmr_clr),
    .en_i    (tmr_en),
    .tc_o    (tmr_tc)
  );

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    reject_d = 1'b0;
    nickel_d = 1'b0;
    tmr_clr  = 1'b0;
    case (state_q)
      StIdle, StCollect: begin
        if ((state_q == StCollect) && cancel_i) begin
          state_d  = StRefund;
          reject_d = coin_any;
        end else if (coin_any) begin
          if (!coin_multi && coin_fits) begin
            credit_d = coin_sum[Bits-1:0];
            tmr_clr  = 1'b1;
            state_d  = (coin_sum >= (Bits + 1)'(Price)) ? StVend : StCollect;
          end else begin
            reject_d = 1'b1;
          end
        end else if ((state_q == StCollect) && tmr_tc) begin
          state_d = StRefund;
        end
      end
      StVend: begin
        reject_d = coin_any;
        if (vend_ack_i) begin
          credit_d = credit_q - PriceW;
          state_d  = (credit_q == PriceW) ? StIdle : StChange;
        end
      end
      StChange, StRefund: begin
        reject_d = coin_any;
        if (credit_q == '0) begin
          state_d = StIdle;
        end else if (hopper_ready_i) begin
          nickel_d = 1'b1;
          if (credit_q <= NickelW) begin
            credit_d = '0;
            state_d  = StIdle;
          end else begin
            credit_d = credit_q - NickelW;
          end
        end
      end
      default: begin
        state_d  = StIdle;
        credit_d = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they line up with state_q.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      credit_q   <= '0;
      accept_q   <= 1'b1;
      reject_q   <= 1'b0;
      vend_req_q <= 1'b0;
      nickel_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      accept_q   <= (state_d == StIdle) || (state_d == StCollect);
      reject_q   <= reject_d;
      vend_req_q <= (state_d == StVend);
      nickel_q   <= nickel_d;
      busy_q     <= (state_d == StVend) || (state_d == StChange) || (state_d == StRefund);
    end
  end

  assign credit_o      = credit_q;
  assign coin_accept_o = accept_q;
  assign coin_reject_o = reject_q;
  assign vend_req_o    = vend_req_q;
  assign nickel_out_o  = nickel_q;
  assign busy_o        = busy_q;

endmodule

// File: doc/vend_sequencer.md
# vend_sequencer

Top-level sequencing controller for the vending machine. It accepts coin pulses and accumulates credit. When the price is reached, it runs a vend handshake with the product dispenser, then pays change or refunds as a stream of nickel pulses. It sits between the coin-acceptor front end and the dispenser/coin-hopper drivers, and owns the credit register that those units share.

## Interface
- BITS, 6, credit width; must hold PRICE + 20 (max overshoot).
- PRICE, 25, vend price in cents; multiple of 5.
- TIMEOUT, 1000, idle cycles in COLLECT before automatic refund.
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- c5, c10, c25  in  1 each  single-cycle coin pulses, expected one-hot.
- cancel  in  1  single-cycle customer refund request.
- vend_ack  in  1  dispenser accepted vend; sampled only in VEND.
- hopper_ready  in  1  coin hopper can take a nickel this cycle.
- credit  out  BITS  current credit in cents.
- coin_accept  out  1  high in IDLE/COLLECT only.
- coin_reject  out  1  one-cycle pulse: coin returned to the customer unrecorded.
- vend_req  out  1  level; high throughout VEND.
- nickel_out  out  1  one-cycle pulse per 5-cent coin paid out.
- busy  out  1  high in VEND, CHANGE, REFUND.

## Operation
- States:
  - IDLE: credit = 0.
  - COLLECT: 0 < credit < PRICE.
  - VEND.
  - CHANGE.
  - REFUND.
- Coin value: c5 = 5, c10 = 10, c25 = 25.
  - Any multi-hot coin combination → coin ignored, coin_reject pulses.
- IDLE/COLLECT: a valid coin adds its value to credit.
  - New credit ≥ PRICE → VEND.
  - Otherwise → COLLECT.
- COLLECT + cancel → REFUND. If cancel and a coin arrive in the same cycle, cancel wins and the coin is rejected.
- IDLE + cancel → no effect.
- Inactivity counter:
  - Clears on every accepted coin and on entry to COLLECT.
  - Reaching TIMEOUT in COLLECT → REFUND.
- VEND:
  - vend_req held high.
  - Coins are rejected.
  - cancel is ignored.
  - On vend_ack, credit ← credit − PRICE. Result 0 → IDLE, else → CHANGE.
- CHANGE/REFUND:
  - In each cycle with hopper_ready = 1: nickel_out pulses and credit −= 5.
  - When credit reaches 0 → IDLE.
  - Coins are rejected.
  - cancel is ignored.
- Credit arithmetic:
  - Unsigned, never wraps.
  - A coin that would exceed 2^BITS−1 is rejected.

## Timing
- Reset values:
  - state = IDLE, credit = 0, coin_accept = 1.
  - coin_reject, vend_req, nickel_out, busy = 0.
  - Inactivity counter = 0.
- Coin or cancel pulse at edge N → credit, state and outputs updated after edge N+1. Latency is 1 cycle.
- vend_req rises the cycle after the price-reaching coin is sampled.
- vend_req falls the cycle after vend_ack is sampled high.
- vend_ack while not in VEND → ignored.
- coin_reject is a registered pulse, 1 cycle after the offending coin.
- nickel_out is a registered pulse, asserted in the cycle after hopper_ready is sampled high. A continuous hopper_ready gives back-to-back nickels.
- The last nickel and the state return to IDLE occur on the same edge. A coin on the following cycle is accepted.
- Reset mid-operation (any state): return to IDLE and discard credit. Partially paid change is not resumed.

## Structure
- Shared package vend_pkg holds:
  - State enum (IDLE, COLLECT, VEND, CHANGE, REFUND).
  - Coin value constants (5, 10, 25).
  - Default PRICE.
- One sub-module, inactivity_timer:
  - Parameterised down-counter with clear and enable inputs and a terminal-count pulse.
  - Instantiated once for the COLLECT timeout.
- Everything else is a single registered FSM plus the credit datapath in vend_sequencer.

## Test plan
- c10, c10, c5 (PRICE 25) → credit 10, 20, 25. vend_req high; ack after 3 cycles → credit 0, IDLE, no nickel_out.
- c25 at credit 20 → credit 45, VEND. After ack → credit 20, CHANGE. hopper_ready constant → 4 back-to-back nickel_out pulses, then IDLE.
- c10 then cancel, with hopper_ready toggling 1,0,1 → 2 nickel_out pulses, aligned to the ready cycles. Credit 10 → 5 → 0.
- c5 and c10 asserted together → coin_reject 1 cycle later, credit unchanged. c25 during VEND → coin_reject, credit unchanged.
- c5 then TIMEOUT idle cycles (set to 8) → REFUND, 1 nickel_out, IDLE. cancel in the same cycle as c10 in COLLECT → coin rejected, refund of the prior credit only.
- reset asserted in CHANGE with 15 remaining → next cycle credit 0, IDLE, nickel_out 0, vend_req 0.
